eth_frame_gen: RTL and testbench
================================

ETH_FRAME_GEN -- requirements
Module: eth_frame_gen

Interface
REQ-001 SHALL have port clock, input, 1: sole clock; all logic on its rising edge.
REQ-002 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1: request to transmit one frame.
REQ-004 SHALL have port dst_addr, input, 48: destination address; [47:40] transmitted first.
REQ-005 SHALL have port src_addr, input, 48: source address; [47:40] transmitted first.
REQ-006 SHALL have port type_length, input, 16: type/length field; [15:8] transmitted first.
REQ-007 SHALL have port payload_len, input, 11: payload byte count including FCS bytes (FCS supplied by the upstream source, not computed here); 0 to 2047.
REQ-008 SHALL have port ifg_len, input, 4: inter-frame gap length in cycles; 0 is treated as 1.
REQ-009 SHALL have port payload_byte, input, 8: next payload byte from a show-ahead source.
REQ-010 SHALL have port payload_rd, output, 1: payload_byte is consumed in this cycle.
REQ-011 SHALL have port data, output, 8: byte stream to the packet detector's data input.
REQ-012 SHALL have port control, output, 1: 1 = frame byte, 0 = idle/IFG byte; drives the packet detector's control input.
REQ-013 SHALL have port busy, output, 1: start will not be accepted this cycle.
REQ-014 SHALL have port done, output, 1: one-cycle pulse on the final IFG cycle of a frame.
REQ-015 SHALL have port frame_count, output, 4: number of completed frames, modulo 16.

Function
REQ-016 SHALL implement states IDLE, PREAMBLE, SFD, DST, SRC, TL, PAYLOAD, IFG, with a byte counter per state.
REQ-017 SHALL accept start only when in IDLE, or in the last IFG cycle; busy SHALL be 0 in exactly those cycles. start while busy=1 SHALL be ignored.
REQ-018 On acceptance, SHALL capture dst_addr, src_addr, type_length, payload_len and ifg_len; later changes to these inputs SHALL not affect the frame in flight.
REQ-019 data and control SHALL be registered; the first preamble byte SHALL appear the cycle after start is accepted.
REQ-020 PREAMBLE: 7 cycles data=0x55; SFD: 1 cycle data=0xD5; DST: 6 bytes; SRC: 6 bytes; TL: 2 bytes; control=1 throughout.
REQ-021 PAYLOAD: payload_len cycles, control=1. payload_rd SHALL be combinational and high in the cycle in which payload_byte is sampled. The sampled byte SHALL appear on data the following cycle. Exactly payload_len payload_rd pulses SHALL occur per frame.
REQ-022 payload_len=0 SHALL skip PAYLOAD (TL goes directly to IFG), with no payload_rd pulse.
REQ-023 IFG: max(ifg_len,1) cycles of control=0, data=0x00; done=1 and frame_count increments (15 wraps to 0) in the last IFG cycle.
REQ-024 If start is accepted in the last IFG cycle, PREAMBLE SHALL follow immediately (back-to-back frames with exactly the programmed gap); otherwise go to IDLE.
REQ-025 IDLE SHALL output control=0, data=0x00, payload_rd=0.

Reset
REQ-026 While reset=1: state=IDLE, data=0x00, control=0, busy=0, done=0, payload_rd=0, frame_count=0; start is ignored in the reset cycle.
REQ-027 Reset asserted mid-frame SHALL abort the frame: the next cycle outputs the idle byte, there is no done pulse, and frame_count=0.

Verification
REQ-028 Reset; start with dst=010203040506, src=FFFEFDFCFBFA, tl=0800, payload_len=50 (49x0x55, 0x56), ifg_len=1 -> expect 7x55, D5, 01..06, FF..FA, 08, 00, payload bytes: 72 control=1 cycles, then 1 control=0 cycle with done=1 and frame_count=1.
REQ-029 start held high, ifg_len=4, 3 frames -> exactly 4 control=0 cycles between frames; frame_count ends at 3; 150 payload_rd pulses in total.
REQ-030 start pulsed during DST of an active frame -> ignored; only one frame sent; frame_count increments by 1.
REQ-031 reset asserted during SRC byte 3 -> next cycle control=0, data=00, frame_count=0; a subsequent start produces a complete, correct frame.
REQ-032 payload_len=0, ifg_len=0 -> 22 control=1 cycles, 1 IFG cycle, no payload_rd pulses.
REQ-033 17 frames sent back-to-back -> frame_count wraps 15 -> 0 -> 1.

Source files
------------

// File: rtl/eth_frame_gen_if.sv
// rtl/eth_frame_gen_if.sv - Start/header inputs, payload fetch and byte-stream outputs of the frame generator
interface eth_frame_gen_if;
    logic        start;
    logic [47:0] dst_addr;
    logic [47:0] src_addr;
    logic [15:0] type_length;
    logic [10:0] payload_len;
    logic [3:0]  ifg_len;
    logic [7:0]  payload_byte;
    logic        payload_rd;
    logic [7:0]  data;
    logic        control;
    logic        busy;
    logic        done;
    logic [3:0]  frame_count;

    modport master (
        output start, dst_addr, src_addr, type_length, payload_len, ifg_len, payload_byte,
        input  payload_rd, data, control, busy, done, frame_count
    );

    modport slave (
        input  start, dst_addr, src_addr, type_length, payload_len, ifg_len, payload_byte,
        output payload_rd, data, control, busy, done, frame_count
    );
endinterface

// File: rtl/eth_frame_gen.sv
// rtl/eth_frame_gen.sv - Ethernet frame byte-stream generator: preamble, SFD, header, payload, IFG
module eth_frame_gen (
    input  logic           clock,
    input  logic           reset,
    eth_frame_gen_if.slave bus
);
    typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DST, SRC, TL, PAYLOAD, IFG} state_t;

    state_t       state;
    logic [10:0]  cnt;
    logic [111:0] hdr;
    logic [10:0]  len_q;
    logic [3:0]   ifg_q;
    logic [3:0]   ifg_last;
    logic         last_ifg;
    logic         pay_last;
    logic         busy;
    logic         accept;

    assign ifg_last = (ifg_q == 4'd0) ? 4'd0 : ifg_q - 4'd1;
    assign last_ifg = (state == IFG) && (cnt == {7'd0, ifg_last});
    assign pay_last = (cnt == len_q - 11'd1);
    assign busy     = !reset && !((state == IDLE) || last_ifg);
    assign accept   = bus.start && !busy;
    assign bus.busy = busy;

    // Show-ahead fetch: the byte sampled now is presented on data next cycle.
    assign bus.payload_rd = !reset &&
        (((state == TL) && (cnt == 11'd1) && (len_q != 11'd0)) ||
         ((state == PAYLOAD) && !pay_last));

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            hdr             <= '0;
            len_q           <= '0;
            ifg_q           <= '0;
            bus.data        <= 8'h00;
            bus.control     <= 1'b0;
            bus.done        <= 1'b0;
            bus.frame_count <= 4'd0;
        end else begin
            bus.done <= 1'b0;
            if (accept) begin
                hdr         <= {bus.dst_addr, bus.src_addr, bus.type_length};
                len_q       <= bus.payload_len;
                ifg_q       <= bus.ifg_len;
                state       <= PREAMBLE;
                cnt         <= '0;
                bus.data    <= 8'h55;
                bus.control <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        bus.data    <= 8'h00;
                        bus.control <= 1'b0;
                    end
                    PREAMBLE: begin
                        if (cnt == 11'd6) begin
                            state    <= SFD;
                            cnt      <= '0;
                            bus.data <= 8'hD5;
                        end else begin
                            cnt      <= cnt + 11'd1;
                            bus.data <= 8'h55;
                        end
                    end
                    // Header bytes leave MSB-first from one shift register.
                    SFD: begin
                        state    <= DST;
                        cnt      <= '0;
                        bus.data <= hdr[111:104];
                        hdr      <= hdr << 8;
                    end
                    DST, SRC: begin
                        if (cnt == 11'd5) begin
                            state <= (state == DST) ? SRC : TL;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 11'd1;
                        end
                        bus.data <= hdr[111:104];
                        hdr      <= hdr << 8;
                    end
                    TL: begin
                        if (cnt == 11'd0) begin
                            cnt      <= 11'd1;
                            bus.data <= hdr[111:104];
                            hdr      <= hdr << 8;
                        end else if (len_q != 11'd0) begin
                            state    <= PAYLOAD;
                            cnt      <= '0;
                            bus.data <= bus.payload_byte;
                        end else begin
                            state       <= IFG;
                            cnt         <= '0;
                            bus.data    <= 8'h00;
                            bus.control <= 1'b0;
                            if (ifg_last == 4'd0) begin
                                bus.done        <= 1'b1;
                                bus.frame_count <= bus.frame_count + 4'd1;
                            end
                        end
                    end
                    PAYLOAD: begin
                        if (pay_last) begin
                            state       <= IFG;
                            cnt         <= '0;
                            bus.data    <= 8'h00;
                            bus.control <= 1'b0;
                            if (ifg_last == 4'd0) begin
                                bus.done        <= 1'b1;
                                bus.frame_count <= bus.frame_count + 4'd1;
                            end
                        end else begin
                            cnt      <= cnt + 11'd1;
                            bus.data <= bus.payload_byte;
                        end
                    end
                    IFG: begin
                        bus.data    <= 8'h00;
                        bus.control <= 1'b0;
                        if (last_ifg) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 11'd1;
                            if (cnt + 11'd1 == {7'd0, ifg_last}) begin
                                bus.done        <= 1'b1;
                                bus.frame_count <= bus.frame_count + 4'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_eth_frame_gen.sv
// tb/tb_eth_frame_gen.sv - Self-checking bench for eth_frame_gen
module tb_eth_frame_gen;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    eth_frame_gen_if bus();
    eth_frame_gen dut (.clock(clk), .reset(rst), .bus(bus));

    typedef struct packed {
        logic       ctrl;
        logic [7:0] data;
        logic       done;
        logic       rd;
    } rec_t;

    typedef struct {
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] tl;
        bit          pat;
        int          len;
        int          ifg;
        int          exp_c1;
        int          exp_c0;
        int          exp_rd;
    } vec_t;

    logic [7:0]  pl_mem [16384];
    logic [13:0] pl_idx = '0;
    logic [13:0] mdl_idx = '0;
    logic [13:0] cons_idx = '0;
    rec_t        exp_q[$];
    int          fc_m = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    bit          chk_en = 1'b0;

    assign bus.payload_byte = pl_mem[pl_idx];
    always @(posedge clk) if (bus.payload_rd === 1'b1) pl_idx <= pl_idx + 14'd1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: bound expired, event not seen at %0t", nm, $time);
    endtask

    function automatic rec_t mk(input logic c, input logic [7:0] d, input logic dn, input logic r);
        rec_t x;
        x = '{c, d, dn, r};
        return x;
    endfunction

    // Reference: whole frame expanded into per-cycle records when start is accepted.
    task automatic push_frame();
        logic [111:0] h;
        int len, n;
        h   = {bus.dst_addr, bus.src_addr, bus.type_length};
        len = int'(bus.payload_len);
        n   = (bus.ifg_len == 0) ? 1 : int'(bus.ifg_len);
        for (int i = 0; i < 7; i++) exp_q.push_back(mk(1'b1, 8'h55, 1'b0, 1'b0));
        exp_q.push_back(mk(1'b1, 8'hD5, 1'b0, 1'b0));
        for (int i = 0; i < 14; i++)
            exp_q.push_back(mk(1'b1, 8'((h >> (8 * (13 - i))) & 112'hFF), 1'b0, (i == 13) && (len > 0)));
        for (int j = 0; j < len; j++)
            exp_q.push_back(mk(1'b1, pl_mem[mdl_idx + 14'(j)], 1'b0, j < len - 1));
        mdl_idx = mdl_idx + 14'(len);
        for (int k = 0; k < n; k++) exp_q.push_back(mk(1'b0, 8'h00, k == n - 1, 1'b0));
    endtask

    always @(negedge clk) begin
        rec_t e;
        logic acc;
        if (exp_q.size() > 0) e = exp_q[0];
        else e = '0;
        if (chk_en) begin
            chk("control", bus.control, e.ctrl);
            chk("data", bus.data, e.data);
            chk("done", bus.done, e.done);
            chk("frame_count", bus.frame_count, (fc_m + (e.done ? 1 : 0)) % 16);
            chk("busy", bus.busy, (rst || exp_q.size() <= 1) ? 1'b0 : 1'b1);
            chk("payload_rd", bus.payload_rd, rst ? 1'b0 : e.rd);
        end
        if (rst) begin
            exp_q.delete();
            fc_m = 0;
            mdl_idx = cons_idx;
        end else begin
            acc = bus.start && (exp_q.size() <= 1);
            if (exp_q.size() > 0) begin
                if (e.rd) cons_idx = cons_idx + 14'd1;
                if (e.done) fc_m = (fc_m + 1) % 16;
                void'(exp_q.pop_front());
            end
            if (acc) push_frame();
        end
    end

    task automatic set_fields(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                              input int len, input int ifg);
        bus.dst_addr    = d;
        bus.src_addr    = s;
        bus.type_length = t;
        bus.payload_len = 11'(len);
        bus.ifg_len     = 4'(ifg);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(posedge clk); #1;
        while (exp_q.size() != 0 && k < 5000) begin
            @(posedge clk); #1;
            k++;
        end
        if (exp_q.size() != 0) timeout_fail("wait_idle");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int exp_fc);
        int c1, c0, rd;
        bit seen;
        wait_idle();
        if (v.pat) for (int j = 0; j < 50; j++) pl_mem[mdl_idx + 14'(j)] = (j == 49) ? 8'h56 : 8'h55;
        set_fields(v.dst, v.src, v.tl, v.len, v.ifg);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        c1 = 0; c0 = 0; rd = 0; seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clk);
            if (bus.control) c1++; else c0++;
            if (bus.payload_rd) rd++;
            if (bus.done) seen = 1'b1;
        end
        if (!seen) timeout_fail("frame_done");
        chk("ctrl1_cycles", c1, v.exp_c1);
        chk("ifg_cycles", c0, v.exp_c0);
        chk("rd_pulses", rd, v.exp_rd);
        chk("frame_count_end", bus.frame_count, exp_fc);
        @(posedge clk); #1;
    endtask

    vec_t tbl[5];

    initial begin
        int d, c0, c1, rd, run;
        tbl[0] = '{48'h010203040506, 48'hFFFEFDFCFBFA, 16'h0800, 1'b1, 50, 1, 72, 1, 50};
        tbl[1] = '{48'hA1A2A3A4A5A6, 48'h111213141516, 16'h86DD, 1'b0, 0, 0, 22, 1, 0};
        tbl[2] = '{48'hFFFFFFFFFFFF, 48'h000000000001, 16'h0001, 1'b0, 1, 15, 23, 15, 1};
        tbl[3] = '{48'h0A0B0C0D0E0F, 48'h123456789ABC, 16'h88F7, 1'b0, 2047, 2, 2069, 2, 2047};
        tbl[4] = '{48'hDEADBEEF0001, 48'hCAFEF00D0002, 16'h0806, 1'b0, 64, 12, 86, 12, 64};

        for (int i = 0; i < 16384; i++) pl_mem[i] = 8'($urandom);
        rst = 1'b1;
        bus.start = 1'b1;
        set_fields('0, '0, '0, 10, 1);
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(tbl[i], i + 1);

        // Abort mid-SRC, then a clean frame.
        do_reset();
        set_fields(48'h112233445566, 48'h778899AABBCC, 16'h0800, 30, 2);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (16) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_control", bus.control, 1'b0);
        chk("abort_data", bus.data, 8'h00);
        chk("abort_frame_count", bus.frame_count, 4'd0);
        @(posedge clk); #1;
        run_vec(tbl[0], 1);

        // Start pulsed during DST is ignored.
        do_reset();
        set_fields(48'h0102030405AA, 48'h0A0908070605, 16'h0800, 20, 3);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_idle();
        c1 = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.control) c1++;
        end
        chk("ignored_start_quiet", c1, 0);
        chk("ignored_start_fc", bus.frame_count, 4'd1);
        @(posedge clk); #1;

        // Start held high: three back-to-back frames with a 4-cycle gap.
        do_reset();
        set_fields(48'h020406080A0C, 48'h010305070911, 16'h0800, 50, 4);
        bus.start = 1'b1;
        @(posedge clk); #1;
        d = 0; c0 = 0; rd = 0; run = 0;
        for (int k = 0; k < 1000 && d < 3; k++) begin
            @(negedge clk);
            if (bus.control) begin
                if (run > 0) chk("b2b_gap", run, 4);
                run = 0;
            end else begin
                c0++;
                run++;
            end
            if (bus.payload_rd) rd++;
            if (bus.done) begin
                d++;
                if (d == 2) begin
                    @(posedge clk); #1;
                    bus.start = 1'b0;
                end
            end
        end
        if (d < 3) timeout_fail("b2b_frames");
        chk("b2b_ctrl0", c0, 12);
        chk("b2b_rd", rd, 150);
        chk("b2b_fc", bus.frame_count, 4'd3);
        wait_idle();

        // 17 minimal frames: frame_count wraps 15 -> 0 -> 1.
        do_reset();
        set_fields(48'h1, 48'h2, 16'h3, 0, 0);
        bus.start = 1'b1;
        @(posedge clk); #1;
        d = 0;
        for (int k = 0; k < 1000 && d < 17; k++) begin
            @(negedge clk);
            if (bus.done) begin
                d++;
                chk("wrap_count", bus.frame_count, d % 16);
                if (d == 16) begin
                    @(posedge clk); #1;
                    bus.start = 1'b0;
                end
            end
        end
        if (d < 17) timeout_fail("wrap_frames");
        wait_idle();

        // Random traffic; inputs churn while frames are in flight.
        for (int c = 0; c < 3000; c++) begin
            bus.start       = ($urandom_range(0, 3) == 0);
            bus.dst_addr    = 48'({$urandom(), $urandom()});
            bus.src_addr    = 48'({$urandom(), $urandom()});
            bus.type_length = 16'($urandom());
            bus.payload_len = 11'($urandom_range(0, 90));
            bus.ifg_len     = 4'($urandom());
            rst             = ($urandom_range(0, 299) == 0);
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        rst = 1'b0;
        wait_idle();
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
